dm_access_unit: RTL
===================

// Module: dm_access_unit
// PURPOSE
//  Initiator side of the dm data-memory port (addr/ctrl_w/ctrl_r/wdata/rdata).
//  Sits in the MEM stage between the pipeline and dm. Accepts byte/half/word
//  load and store requests on byte addresses and sequences the dm cycles.
//  Loads are extracted and sign- or zero-extended. Sub-word stores use a
//  read-modify-write. Misaligned or illegal-size requests are rejected.
// PARAMETERS
//  ADDR_W  10  dm word-address width (dm depth = 2**ADDR_W words)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit idle; request accepted when valid&&ready
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned (bits [7:0]/[15:0]/[31:0])
//  resp_valid  out  1       one-cycle completion pulse
//  resp_err    out  1       valid with resp_valid: misaligned or illegal size
//  resp_rdata  out  32      load result, valid with resp_valid (0 for stores/err)
//  dm_addr     out  ADDR_W  dm word address = latched req_addr[ADDR_W+1:2]
//  dm_ctrl_w   out  1       dm write strobe; dm writes on clk edge ending the cycle
//  dm_ctrl_r   out  1       dm read strobe; dm_rdata valid in the following cycle
//  dm_wdata    out  32      dm write data (full word)
//  dm_rdata    in   32      dm read data
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1. All of the following are 0: resp_valid,
//   resp_err, resp_rdata, dm_ctrl_w, dm_ctrl_r, dm_addr, dm_wdata.
//  FSM states: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
//  Accept cycle T (IDLE, valid&&ready): latch the request. Next state:
//   - misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: RESP with err
//   - word store: WR
//   - load or sub-word store: RD
//  RD: dm_ctrl_r=1 for exactly one cycle -> CAP.
//  CAP: register dm_rdata.
//   - load: extract lane, extend -> RESP
//   - store: merge new lane into the word -> WR
//  WR: dm_ctrl_w=1 for exactly one cycle, dm_wdata = full/merged word -> RESP.
//  RESP: resp_valid=1 for one cycle -> IDLE. No backpressure on the response.
//  Latency (resp_valid cycle):
//   - word store T+2; load T+3; sub-word store T+4; error T+1
//  Throughput: next request can be accepted in the cycle after RESP.
//  Lanes are little-endian:
//   - byte lane = addr[1:0], bits [8*lane+7 : 8*lane]
//   - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]]
//  Error path issues no dm strobe. resp_rdata=0 on stores and errors.
//  dm_ctrl_r and dm_ctrl_w are never high in the same cycle. Both are 0
//   outside RD/WR. dm_addr/dm_wdata hold their last value while idle.
//  req_* are ignored while busy (req_ready=0). No queueing.
//  rst_n low at any time: state goes to IDLE and strobes drop immediately
//   (asynchronous). An interrupted store may be lost. No resp_valid is issued
//   for the aborted request.
// TESTING
//  1 word store addr 0x8, data 0xDEADBEEF -> T+1 ctrl_w=1, dm_addr=2, dm_wdata=0xDEADBEEF;
//    T+2 resp_valid=1, err=0.
//  2 mem[2]=0xDEADBEEF, byte load addr 0x9: signed -> 0xFFFFFFBE at T+3; unsigned -> 0x000000BE.
//  3 mem[2]=0xDEADBEEF, half store addr 0xA data 0x1234 -> T+1 ctrl_r; T+3 ctrl_w,
//    wdata=0x1234BEEF; resp at T+4. A following word load of addr 0x8 returns 0x1234BEEF.
//  4 word load addr 0x6 (also size=11) -> resp_valid at T+1, err=1; ctrl_r/ctrl_w stay 0.
//  5 req_valid held for two back-to-back loads -> req_ready=0 from T+1 to T+3;
//    second request accepted at T+4; both results correct, in order.
//  6 rst_n low during WR of a byte store -> ctrl_w drops same cycle, req_ready=1,
//    no resp_valid; a new load after reset release completes normally.

Source files
------------

// File: rtl/dm_access_if.sv
// Request/response handshake plus the dm data-memory port of dm_access_unit.
// slave = the access unit; master = pipeline/dm side driving it.
interface dm_access_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_ctrl_w;
  logic              dm_ctrl_r;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           dm_addr, dm_ctrl_w, dm_ctrl_r, dm_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           dm_addr, dm_ctrl_w, dm_ctrl_r, dm_wdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// MEM-stage initiator for the dm port: byte/half/word loads with extension,
// sub-word stores via read-modify-write, misaligned/illegal requests rejected.
module dm_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_access_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  logic [2:0]        state;
  req_t              rq;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              bad;
  logic [31:0]       sh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ld_val;
  logic [31:0]       merged;
  logic              unused_ok;

  assign unused_ok = ^bus.req_addr[31:ADDR_W+2];

  assign bad = (bus.req_size == 2'b11) ||
               (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Lane extraction and merge both work on the word returned during CAP.
  always_comb begin
    sh     = bus.dm_rdata >> {rq.lane, 3'b000};
    byte_v = sh[7:0];
    half_v = rq.lane[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    case (rq.size)
      2'b00:   ld_val = {{24{rq.sgn & byte_v[7]}}, byte_v};
      2'b01:   ld_val = {{16{rq.sgn & half_v[15]}}, half_v};
      default: ld_val = bus.dm_rdata;
    endcase
    merged = bus.dm_rdata;
    if (rq.size == 2'b00) merged[{rq.lane, 3'b000} +: 8] = rq.wdata[7:0];
    else                  merged[{rq.lane[1], 4'b0000} +: 16] = rq.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rq      <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.req_valid) begin
          rq      <= '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                       lane: bus.req_addr[1:0], wdata: bus.req_wdata[15:0]};
          err_q   <= bad;
          rdata_q <= '0;
          addr_q  <= bus.req_addr[ADDR_W+1:2];
          if (bad) state <= S_RESP;
          else if (bus.req_we && bus.req_size == 2'b10) begin
            wdata_q <= bus.req_wdata;
            state   <= S_WR;
          end else state <= S_RD;
        end
        S_RD:  state <= S_CAP;
        S_CAP: if (rq.we) begin
          wdata_q <= merged;
          state   <= S_WR;
        end else begin
          rdata_q <= ld_val;
          state   <= S_RESP;
        end
        S_WR:    state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.dm_ctrl_r  = (state == S_RD);
  assign bus.dm_ctrl_w  = (state == S_WR);
  assign bus.dm_addr    = addr_q;
  assign bus.dm_wdata   = wdata_q;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_err   = (state == S_RESP) & err_q;
  assign bus.resp_rdata = (state == S_RESP) ? rdata_q : 32'd0;

endmodule
